// File: rtl/start_token_reader_pkg.sv
// Shared defaults and the decoded occupancy-state encoding for the start token FIFO.
package start_token_reader_pkg;

  localparam int DEF_DATA_WIDTH = 1;
  localparam int DEF_ADDR_WIDTH = 1;
  localparam int DEF_DEPTH      = 2;

  // Total tokens the default configuration can hold (store plus output register).
  localparam int CAP = DEF_DEPTH + 1;

  // Occupancy view used by assertions only; the datapath has no state register.
  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_HEAD     = 2'd1,
    ST_BUFFERED = 2'd2,
    ST_FULL     = 2'd3
  } tok_state_e;

endpackage

// File: rtl/start_token_store.sv
// SRL-style shift store: a write shifts every entry up by one and lands the new
// token in entry 0, so the oldest token sits at the highest occupied index.
module start_token_store
  import start_token_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;

  // Shift on write; contents are deliberately left unreset (occupancy lives in the controller).
  always_ff @(posedge clk) begin
    if (we) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  // Addressed combinational read; addresses beyond DEPTH read as zero.
  always_comb begin
    dout = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr == ADDR_WIDTH'(i)) dout = mem[i];
    end
  end

endmodule

// File: rtl/start_token_reader.sv
// Read-side controller for the start-propagation token FIFO: tracks occupancy,
// addresses the oldest stored token and feeds a registered ap_start/ap_ready head.
module start_token_reader
  import start_token_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  output logic                  pe_start,
  output logic [DATA_WIDTH-1:0] pe_din,
  input  logic                  pe_ready,
  output logic [ADDR_WIDTH:0]   usedw,
  output logic                  err_overflow
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam int                  CAPACITY = DEPTH + 1;

  logic [ADDR_WIDTH:0]   cnt, cnt_nxt;
  logic                  out_valid, out_valid_nxt;
  logic [DATA_WIDTH-1:0] out_data;
  logic [DATA_WIDTH-1:0] store_dout;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  full_n;
  logic [ADDR_WIDTH:0]   usedw_q;
  logic                  ovf_q;
  logic                  push, pop, load;

  assign push = if_write && full_n;
  assign pop  = out_valid && pe_ready;
  assign load = (cnt != '0) && (!out_valid || pop);

  // Oldest token lives at cnt-1; the value at cnt==0 is never consumed.
  assign rd_addr = ADDR_WIDTH'(cnt - CNT_ONE);

  start_token_store #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_store (
    .clk  (ap_clk),
    .we   (push),
    .din  (if_din),
    .addr (rd_addr),
    .dout (store_dout)
  );

  // Next occupancy: a push and a load in the same cycle cancel, the shift keeps cnt-1 pointing at the oldest.
  always_comb begin
    cnt_nxt = cnt;
    if (push && !load)      cnt_nxt = cnt + CNT_ONE;
    else if (!push && load) cnt_nxt = cnt - CNT_ONE;
  end

  // Head register valid: refilled on load, emptied by a pop with nothing behind it.
  always_comb begin
    out_valid_nxt = out_valid;
    if (load)     out_valid_nxt = 1'b1;
    else if (pop) out_valid_nxt = 1'b0;
  end

  // Occupancy, head stage and the registered status flags.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      full_n    <= 1'b1;
      usedw_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      out_valid <= out_valid_nxt;
      if (load) out_data <= store_dout;
      full_n    <= (cnt_nxt != DEPTH_C);
      usedw_q   <= cnt_nxt + {{ADDR_WIDTH{1'b0}}, out_valid_nxt};
      if (if_write && !full_n) ovf_q <= 1'b1;
    end
  end

  assign if_full_n    = full_n;
  assign pe_start     = out_valid;
  assign pe_din       = out_data;
  assign usedw        = usedw_q;
  assign err_overflow = ovf_q;

  // Decode of the occupancy view checked by the assertions below.
  tok_state_e state_dec;
  always_comb begin
    state_dec = ST_EMPTY;
    if (out_valid) begin
      if (cnt == '0)          state_dec = ST_HEAD;
      else if (cnt == DEPTH_C) state_dec = ST_FULL;
      else                     state_dec = ST_BUFFERED;
    end
  end

  a_cnt_range: assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
    cnt <= DEPTH_C);

  a_usedw_cap: assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
    32'(usedw_q) <= CAPACITY);

  a_full_flag: assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
    full_n == (cnt != DEPTH_C));

  a_full_state: assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
    (state_dec == ST_FULL) |-> !full_n);

  a_usedw_sum: assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
    usedw_q == cnt + {{ADDR_WIDTH{1'b0}}, out_valid});

  a_transient: assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
    (state_dec == ST_EMPTY && cnt != '0) |=> out_valid);

  a_hold: assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
    (out_valid && !pe_ready) |=> (out_valid && $stable(out_data)));

endmodule

// File: tb/tb_start_token_reader.sv
// Bench for start_token_reader: directed scenarios plus random traffic against a
// queue-based model of the FIFO (store queue + head register).
module tb_start_token_reader;

  localparam int DW    = 1;
  localparam int AW    = 1;
  localparam int DEPTH = 2;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n = 1'b0;
  logic          if_write = 1'b0;
  logic [DW-1:0] if_din = '0;
  logic          pe_ready = 1'b0;
  logic          if_full_n, pe_start, err_overflow;
  logic [DW-1:0] pe_din;
  logic [AW:0]   usedw;

  int n_chk  = 0;
  int n_fail = 0;

  logic [DW-1:0] m_store[$];
  logic          m_hv = 1'b0;
  logic [DW-1:0] m_hd = '0;
  logic          m_err = 1'b0;
  logic [DW-1:0] accepted[$];
  logic [DW-1:0] popped[$];

  start_token_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .ap_clk       (ap_clk),
    .ap_rst_n     (ap_rst_n),
    .if_write     (if_write),
    .if_din       (if_din),
    .if_full_n    (if_full_n),
    .pe_start     (pe_start),
    .pe_din       (pe_din),
    .pe_ready     (pe_ready),
    .usedw        (usedw),
    .err_overflow (err_overflow)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_store.delete();
    m_hv  = 1'b0;
    m_hd  = '0;
    m_err = 1'b0;
    accepted.delete();
    popped.delete();
  endtask

  // One clock of FIFO behaviour: the head is refilled from the oldest stored token, then the push lands.
  task automatic model_step(input logic w, input logic [DW-1:0] d, input logic r);
    logic acc, pop, ld;
    acc = w && (m_store.size() != DEPTH);
    pop = m_hv && r;
    ld  = (m_store.size() != 0) && (!m_hv || pop);
    if (w && !acc) m_err = 1'b1;
    if (ld) m_hd = m_store.pop_front();
    m_hv = ld ? 1'b1 : (pop ? 1'b0 : m_hv);
    if (acc) begin
      m_store.push_back(d);
      accepted.push_back(d);
    end
  endtask

  task automatic check_outputs();
    chk("pe_start", 32'(pe_start), 32'(m_hv));
    if (m_hv) chk("pe_din", 32'(pe_din), 32'(m_hd));
    chk("usedw", 32'(usedw), 32'(m_store.size()) + 32'(m_hv));
    chk("if_full_n", 32'(if_full_n), 32'(m_store.size() != DEPTH));
    chk("err_overflow", 32'(err_overflow), 32'(m_err));
    if (pe_start && pe_ready && ap_rst_n) popped.push_back(pe_din);
  endtask

  // Drive for one cycle, check mid-cycle, then advance the model at the edge.
  task automatic cycle(input logic w, input logic [DW-1:0] d, input logic r);
    if_write = w;
    if_din   = d;
    pe_ready = r;
    @(negedge ap_clk);
    check_outputs();
    @(posedge ap_clk);
    if (ap_rst_n) model_step(w, d, r);
    #1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1);
    chk({tag, "_count"}, 32'(popped.size()), 32'(accepted.size()));
    for (int i = 0; i < popped.size() && i < accepted.size(); i++)
      chk({tag, "_order"}, 32'(popped[i]), 32'(accepted[i]));
    popped.delete();
    accepted.delete();
  endtask

  initial begin
    model_reset();
    @(posedge ap_clk);
    #1;

    // Reset held with random inputs.
    for (int i = 0; i < 4; i++) cycle(1'($urandom), DW'($urandom), 1'($urandom));
    ap_rst_n = 1'b1;

    // Single token round trip: usedw 0,1,1,0.
    cycle(1'b1, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    chk("single_start", 32'(pe_start), 32'd1);
    chk("single_din", 32'(pe_din), 32'd1);
    cycle(1'b0, 1'b0, 1'b1);
    chk("single_after_pop", 32'(usedw), 32'd0);
    drain("single");

    // Ordering under backpressure.
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    chk("bp_usedw", 32'(usedw), 32'd3);
    chk("bp_full_n", 32'(if_full_n), 32'd0);
    cycle(1'b0, 1'b0, 1'b1);
    chk("bp_seq1", 32'(pe_din), 32'd0);
    cycle(1'b0, 1'b0, 1'b1);
    chk("bp_seq2", 32'(pe_din), 32'd1);
    drain("order");

    // Overflow: a fourth push is dropped and the flag sticks.
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    chk("ovf_flag", 32'(err_overflow), 32'd1);
    chk("ovf_usedw", 32'(usedw), 32'd3);
    drain("overflow");
    chk("ovf_sticky", 32'(err_overflow), 32'd1);

    // Simultaneous push and pop from HEAD+1.
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, DW'(i % 2), 1'b1);
      chk("simul_usedw", 32'(usedw), 32'd2);
    end
    drain("simul");

    // Reset mid-operation from FULL, asserted away from any edge.
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    chk("pre_rst_usedw", 32'(usedw), 32'd3);
    #2 ap_rst_n = 1'b0;
    #1;
    chk("async_pe_start", 32'(pe_start), 32'd0);
    chk("async_usedw", 32'(usedw), 32'd0);
    chk("async_full_n", 32'(if_full_n), 32'd1);
    chk("async_err", 32'(err_overflow), 32'd0);
    model_reset();
    if_write = 1'b0;
    pe_ready = 1'b0;
    @(posedge ap_clk);
    @(negedge ap_clk);
    #1 ap_rst_n = 1'b1;
    @(posedge ap_clk);
    model_step(1'b0, '0, 1'b0);
    #1;
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    chk("rst_new_start", 32'(pe_start), 32'd1);
    chk("rst_new_din", 32'(pe_din), 32'd0);
    drain("post_reset");

    // Random traffic.
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 3) != 0), DW'($urandom), 1'($urandom));
    drain("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/start_token_reader.md
Name: start_token_reader

Overview:
- Read-side controller for a start-propagation token FIFO. A producer PE pushes start tokens into an SRL-style shift store. This block pops tokens in order (oldest first) and drives an ap_start/ap_ready handshake into the downstream PE.
- Bundles occupancy tracking, read addressing, a registered output stage, full/empty flags and an overflow flag.
- Sits between the upstream PE's start_write/start_full_n pair and the consumer PE's ap_start/ap_ready.

Parameters:
- DATA_WIDTH, 1: token payload width.
- ADDR_WIDTH, 1: shift-store address width; requires DEPTH <= 2**ADDR_WIDTH.
- DEPTH, 2: shift-store entries. Total capacity is DEPTH+1, including the output register.

Ports:
- ap_clk  in  1  single clock; all state changes on its rising edge.
- ap_rst_n  in  1  asynchronous, active-low reset.
- if_write  in  1  push strobe from producer.
- if_din  in  DATA_WIDTH  pushed token payload.
- if_full_n  out  1  1 = push accepted this cycle.
- pe_start  out  1  token available to consumer (ap_start).
- pe_din  out  DATA_WIDTH  head token payload; stable while pe_start=1.
- pe_ready  in  1  consumer accepts head (ap_ready).
- usedw  out  ADDR_WIDTH+1  total tokens held (store + output register).
- err_overflow  out  1  sticky; set when a push is attempted while full.

Behaviour:
- Reset (async assert): cnt=0, out_valid=0, pe_start=0, pe_din=0, usedw=0, err_overflow=0, if_full_n=1. Store contents are not reset (don't-care). Reset mid-transfer drops every held token; the first cycle after deassert behaves like an empty FIFO.
- Storage: on push, entry[i+1]<=entry[i] and entry[0]<=if_din. Read address = cnt-1, so the oldest token is always read.
- Accept rule: push = if_write && if_full_n, where if_full_n = (cnt != DEPTH), registered from cnt. A push while cnt==DEPTH is ignored and sets err_overflow on the same edge.
- Pop rule: pop = pe_start && pe_ready. pe_start = out_valid.
- Load rule: load = (cnt>0) && (!out_valid || pop).
  - On load: out_data <= entry[cnt-1], and the store read uses the pre-edge cnt.
  - out_valid <= 1 on load; out_valid <= 0 on pop without load.
- Counter:
  - cnt += push - load.
  - Simultaneous push and load leaves cnt unchanged and remains coherent, because the shift moves the other entries up by one.
- Derived states (no explicit FSM register; decoded for assertions):
  - EMPTY: !out_valid, cnt=0.
  - HEAD: out_valid, cnt=0.
  - BUFFERED: out_valid, 0<cnt<DEPTH.
  - FULL: out_valid, cnt=DEPTH.
  - Transitions move by push/pop. !out_valid with cnt>0 is transient and lasts at most one cycle.
- Latency:
  - Push into EMPTY at cycle N: pe_start=1 at N+2.
  - Pop at cycle M with cnt>0: new head valid at M+1, so back-to-back issue is possible.
  - No push-to-output bypass.
- Handshake: while pe_start=1 and pe_ready=0, pe_start and pe_din hold. pe_ready while pe_start=0 is ignored.
- usedw = cnt + out_valid, registered. Maximum value is DEPTH+1.
- Push-and-pop in FULL: if_full_n=0, so the push is rejected. Only the pop advances and cnt drops by 1.

Decomposition:
- Shared package: DATA_WIDTH/ADDR_WIDTH/DEPTH defaults and a localparam CAP=DEPTH+1. The state encoding enum is used for the assertion decode only.
- One sub-module: start_token_store, the DEPTH-entry shift store with a combinational addressed read. It is instantiated with we=push and addr=cnt-1.
- The control logic stays in the top module.

Test Plan (all with DEPTH=2):
- Reset: hold ap_rst_n=0 with random inputs -> pe_start=0, if_full_n=1, usedw=0, err_overflow=0. Assert reset asynchronously mid-cycle -> outputs clear before the next edge.
- Single token: push din=1 at cycle 0, pe_ready=1 -> pe_start=1 and pe_din=1 at cycle 2. Popped at cycle 2; usedw goes 0,1,1,0.
- Ordering/backpressure: push tokens 1,0,1 on consecutive cycles with pe_ready=0.
  - Expect usedw=3 and if_full_n=0.
  - Raise pe_ready -> pe_din sequence 1,0,1 on three consecutive cycles.
- Overflow: fill to usedw=3, then pulse if_write with din=0 -> the token is dropped, err_overflow=1 and stays set. Draining then yields only the original 3 tokens.
- Simultaneous: with usedw=2 (HEAD+1), apply push and pop in the same cycle for 10 cycles with an alternating payload -> usedw stays 2, tokens emerge in order, no loss or duplicate.
- Reset mid-operation: in FULL, pulse ap_rst_n low for 1 cycle -> usedw=0, pe_start=0. The next push shows pe_start 2 cycles later carrying the new payload, not stale data.
